// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 frame receiver and the scan-code decoding
// that consumes its output.
//   ps2_state_e   - receiver FSM state encoding
//   FrameLen      - bits per PS/2 frame (start + 8 data + parity + stop)
//   DataBits      - data bits per frame
//   ScanExtended  - 8'hE0 extended-key prefix
//   ScanBreak     - 8'hF0 key-release prefix
//   odd_parity_ok - true when data plus parity bit hold an odd number of ones
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StData   = 3'd1,
        StParity = 3'd2,
        StStop   = 3'd3,
        StDone   = 3'd4
    } ps2_state_e;

    localparam int unsigned FrameLen = 11;
    localparam int unsigned DataBits = FrameLen - 3;

    localparam logic [7:0] ScanExtended = 8'hE0;
    localparam logic [7:0] ScanBreak    = 8'hF0;

    function automatic logic odd_parity_ok(input logic [DataBits-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_edge_det.sv
// ps2_edge_det: brings the PS/2 clock and data lines into the clk domain and detects falling
// edges of the PS/2 clock.
// Build option: define PS2_GLITCH_FILTER_EN to run the synchronized kbd_clk through a
// FILTER_LEN-sample stability filter before edge detection.
// Ports:
//   clk          - system clock
//   resetN       - asynchronous active-low reset
//   kbd_clk      - raw PS/2 clock line
//   kbd_dat      - raw PS/2 data line
//   kbd_dat_sync - synchronized data line
//   kbd_clk_fall - one-cycle strobe on an accepted kbd_clk falling edge
module ps2_edge_det #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic kbd_clk,
    input  logic kbd_dat,
    output logic kbd_dat_sync,
    output logic kbd_clk_fall
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       lvl;
    logic       lvl_prev_q;

    // Reset to 1: the idle bus level, so release of reset never looks like an edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], kbd_clk};
            dat_sync_q <= {dat_sync_q[0], kbd_dat};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // The filtered level only follows the line after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign lvl = clk_sync_q[1];
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lvl_prev_q <= 1'b1;
        end else begin
            lvl_prev_q <= lvl;
        end
    end

    assign kbd_clk_fall = lvl_prev_q & ~lvl;
    assign kbd_dat_sync = dat_sync_q[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop) and
// presents each correctly received byte with a one-cycle strobe.
// Build option: PS2_GLITCH_FILTER_EN enables the kbd_clk glitch filter in ps2_edge_det.
// Parameters:
//   TIMEOUT_CYCLES - idle clk cycles inside a frame before the frame is abandoned
//   FILTER_LEN     - stable samples needed to accept a kbd_clk level (filter build only)
// Ports:
//   clk        - system clock
//   resetN     - asynchronous active-low reset
//   kbd_clk    - PS/2 clock line (asynchronous)
//   kbd_dat    - PS/2 data line (asynchronous)
//   dout       - last correctly received byte, held between frames
//   dout_new   - one-cycle strobe: dout just updated
//   parity_err - one-cycle strobe: parity check failed
//   frame_err  - one-cycle strobe: bad stop bit or mid-frame timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic [7:0] dout,
    output logic       dout_new,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic dat_s;
    logic fall;

    ps2_edge_det #(
        .FILTER_LEN(FILTER_LEN)
    ) u_edge_det (
        .clk         (clk),
        .resetN      (resetN),
        .kbd_clk     (kbd_clk),
        .kbd_dat     (kbd_dat),
        .kbd_dat_sync(dat_s),
        .kbd_clk_fall(fall)
    );

    ps2_state_e          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic [7:0]          dout_q, dout_d;
    logic                dout_new_q, dout_new_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic                in_frame;
    logic                timeout;

    assign in_frame = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
    assign timeout  = in_frame && (to_cnt_q == ToW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        dout_d       = dout_q;
        dout_new_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // Counts cycles since the last accepted edge; only meaningful inside a frame.
        if (in_frame && !fall && !timeout) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end else begin
            to_cnt_d = '0;
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (fall && !dat_s) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {dat_s, shift_q[DataBits-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StParity: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = StStop;
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StStop: begin
                if (fall) begin
                    // A bad stop bit outranks a parity failure.
                    if (!dat_s) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        parity_err_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        dout_d     = shift_q;
                        dout_new_d = 1'b1;
                        state_d    = StDone;
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            // dout_new is high during this single cycle; any edge here is not a real bit.
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            dout_q       <= 8'h00;
            dout_new_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            dout_q       <= dout_d;
            dout_new_q   <= dout_new_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_new   = dout_new_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed self-checking bench for ps2_frame_rx. The PS/2 bit period is
// shortened and TIMEOUT_CYCLES reduced so the whole run stays short.
module tb_ps2_frame_rx;

    localparam int unsigned TimeoutCycles = 500;
    localparam int          HalfBit       = 20;

    logic       clk     = 1'b0;
    logic       resetN  = 1'b0;
    logic       kbd_clk = 1'b1;
    logic       kbd_dat = 1'b1;
    logic [7:0] dout;
    logic       dout_new;
    logic       parity_err;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // Strobe counters, written only by the monitor below.
    int n_new  = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovl  = 0;
    int b_new, b_perr, b_ferr;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TimeoutCycles),
        .FILTER_LEN    (4)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .kbd_clk   (kbd_clk),
        .kbd_dat   (kbd_dat),
        .dout      (dout),
        .dout_new  (dout_new),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (dout_new === 1'b1) n_new <= n_new + 1;
        if (parity_err === 1'b1) n_perr <= n_perr + 1;
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if ((int'(dout_new) + int'(parity_err) + int'(frame_err)) > 1) n_ovl <= n_ovl + 1;
    end

    task automatic snap();
        @(posedge clk);
        b_new  = n_new;
        b_perr = n_perr;
        b_ferr = n_ferr;
    endtask

    // One PS/2 bit: data set while the clock is high, then a low half period.
    task automatic ps2_bit(input logic b, input logic glitch);
        @(negedge clk);
        kbd_dat = b;
        if (glitch) begin
            repeat (HalfBit / 2) @(negedge clk);
            kbd_clk = 1'b0;
            repeat (2) @(negedge clk);
            kbd_clk = 1'b1;
            repeat (HalfBit / 2 - 2) @(negedge clk);
        end else begin
            repeat (HalfBit) @(negedge clk);
        end
        kbd_clk = 1'b0;
        repeat (HalfBit) @(negedge clk);
        kbd_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int glitch_bit);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i], i == glitch_bit);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, 1'b0);
        kbd_dat = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout: got %h expected 00", dout);
        end
        checks++;
        if ({dout_new, parity_err, frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000",
                               {dout_new, parity_err, frame_err});
        end
        resetN = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        snap_check_dummy: begin end
        @(posedge clk);
        checks++;
        if (n_new - b_new !== 1) begin
            errors++; $display("FAIL good_new_count: got %0d expected 1", n_new - b_new);
        end
        checks++;
        if ((n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin
            errors++; $display("FAIL good_err_count: got %0d expected 0",
                               (n_perr - b_perr) + (n_ferr - b_ferr));
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h1C) begin
            errors++; $display("FAIL good_dout: got %h expected 1c", dout);
        end
    endtask

    task automatic test_parity_error();
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        @(posedge clk);
        checks++;
        if (n_perr - b_perr !== 2) begin
            errors++; $display("FAIL parity_err_count: got %0d expected 2", n_perr - b_perr);
        end
        checks++;
        if ((n_new - b_new) + (n_ferr - b_ferr) !== 0) begin
            errors++; $display("FAIL parity_other_count: got %0d expected 0",
                               (n_new - b_new) + (n_ferr - b_ferr));
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h1C) begin
            errors++; $display("FAIL parity_dout_hold: got %h expected 1c", dout);
        end
    endtask

    // Wrong parity and a zero stop bit: only frame_err may fire.
    task automatic test_bad_stop();
        snap();
        send_frame(8'h29, 1'b1, 1'b0, -1);
        @(posedge clk);
        checks++;
        if (n_ferr - b_ferr !== 1) begin
            errors++; $display("FAIL stop_ferr_count: got %0d expected 1", n_ferr - b_ferr);
        end
        checks++;
        if ((n_new - b_new) + (n_perr - b_perr) !== 0) begin
            errors++; $display("FAIL stop_other_count: got %0d expected 0",
                               (n_new - b_new) + (n_perr - b_perr));
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h1C) begin
            errors++; $display("FAIL stop_dout_hold: got %h expected 1c", dout);
        end
    endtask

    task automatic test_timeout();
        snap();
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        kbd_dat = 1'b1;
        repeat (TimeoutCycles - 50) @(posedge clk);
        checks++;
        if (n_ferr - b_ferr !== 0) begin
            errors++; $display("FAIL timeout_early: got %0d expected 0", n_ferr - b_ferr);
        end
        repeat (100) @(posedge clk);
        checks++;
        if (n_ferr - b_ferr !== 1) begin
            errors++; $display("FAIL timeout_ferr_count: got %0d expected 1", n_ferr - b_ferr);
        end
        checks++;
        if ((n_new - b_new) + (n_perr - b_perr) !== 0) begin
            errors++; $display("FAIL timeout_other_count: got %0d expected 0",
                               (n_new - b_new) + (n_perr - b_perr));
        end
        snap();
        send_frame(8'h29, 1'b0, 1'b1, -1);
        @(posedge clk);
        checks++;
        if (n_new - b_new !== 1) begin
            errors++; $display("FAIL timeout_next_new: got %0d expected 1", n_new - b_new);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h29) begin
            errors++; $display("FAIL timeout_next_dout: got %h expected 29", dout);
        end
    endtask

    task automatic test_idle_high_edge();
        snap();
        ps2_bit(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        checks++;
        if ((n_new - b_new) + (n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin
            errors++; $display("FAIL idle_edge_strobes: got %0d expected 0",
                               (n_new - b_new) + (n_perr - b_perr) + (n_ferr - b_ferr));
        end
        snap();
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        @(posedge clk);
        checks++;
        if (n_new - b_new !== 1) begin
            errors++; $display("FAIL idle_next_new: got %0d expected 1", n_new - b_new);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'hF0) begin
            errors++; $display("FAIL idle_next_dout: got %h expected f0", dout);
        end
    endtask

    task automatic test_reset_mid_frame();
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL midreset_dout: got %h expected 00", dout);
        end
        checks++;
        if ({dout_new, parity_err, frame_err} !== 3'b000) begin
            errors++; $display("FAIL midreset_strobes: got %b expected 000",
                               {dout_new, parity_err, frame_err});
        end
        kbd_dat = 1'b1;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (10) @(negedge clk);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        @(posedge clk);
        checks++;
        if (n_new - b_new !== 1) begin
            errors++; $display("FAIL midreset_next_new: got %0d expected 1", n_new - b_new);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h1C) begin
            errors++; $display("FAIL midreset_next_dout: got %h expected 1c", dout);
        end
    endtask

    task automatic test_back_to_back();
        snap();
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        @(negedge clk);
        checks++;
        if (dout !== 8'hE0) begin
            errors++; $display("FAIL b2b_dout_e0: got %h expected e0", dout);
        end
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        @(negedge clk);
        checks++;
        if (dout !== 8'hF0) begin
            errors++; $display("FAIL b2b_dout_f0: got %h expected f0", dout);
        end
        send_frame(8'h29, 1'b0, 1'b1, -1);
        @(posedge clk);
        checks++;
        if (n_new - b_new !== 3) begin
            errors++; $display("FAIL b2b_new_count: got %0d expected 3", n_new - b_new);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h29) begin
            errors++; $display("FAIL b2b_dout_29: got %h expected 29", dout);
        end
    endtask

    // A 2-cycle low pulse on kbd_clk during data bit 3 of a 0x1C frame.
    task automatic test_glitch();
        snap();
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        @(posedge clk);
`ifdef PS2_GLITCH_FILTER_EN
        checks++;
        if (n_new - b_new !== 1) begin
            errors++; $display("FAIL glitch_new: got %0d expected 1", n_new - b_new);
        end
        checks++;
        if ((n_perr - b_perr) + (n_ferr - b_ferr) !== 0) begin
            errors++; $display("FAIL glitch_errs: got %0d expected 0",
                               (n_perr - b_perr) + (n_ferr - b_ferr));
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h1C) begin
            errors++; $display("FAIL glitch_dout: got %h expected 1c", dout);
        end
`else
        checks++;
        if (n_new - b_new !== 0) begin
            errors++; $display("FAIL glitch_new: got %0d expected 0", n_new - b_new);
        end
        checks++;
        if ((n_perr - b_perr) + (n_ferr - b_ferr) < 1) begin
            errors++; $display("FAIL glitch_errs: got %0d expected at least 1",
                               (n_perr - b_perr) + (n_ferr - b_ferr));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_bad_stop();
        test_timeout();
        test_idle_high_edge();
        test_back_to_back();
        test_reset_mid_frame();
        test_glitch();
        @(posedge clk);
        checks++;
        if (n_ovl !== 0) begin
            errors++; $display("FAIL strobe_overlap: got %0d expected 0", n_ovl);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning idle-mid-frame clk cycles before the frame is abandoned.
REQ-002 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required to accept a kbd_clk level (filter build only).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port kbd_clk  input  1  PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port kbd_dat  input  1  PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port dout  output  8  last correctly received byte.
REQ-008 SHALL have port dout_new  output  1  one-cycle strobe marking a new valid dout.
REQ-009 SHALL have port parity_err  output  1  one-cycle strobe on an odd-parity failure.
REQ-010 SHALL have port frame_err  output  1  one-cycle strobe on a bad stop bit or a timeout.

Function
REQ-011 SHALL pass kbd_clk and kbd_dat through a 2-flop synchronizer each before any use.
REQ-012 SHALL sample synchronized kbd_dat only in the clk cycle a synchronized kbd_clk falling edge is detected.
REQ-013 SHALL implement states IDLE, DATA, PARITY, STOP, DONE.
REQ-014 IDLE: on a falling edge with data 0 (start bit), go to DATA; with data 1, stay in IDLE with no strobe.
REQ-015 DATA: shift 8 bits LSB first, using a 3-bit bit counter; after bit 7, go to PARITY.
REQ-016 PARITY: capture the parity bit, then go to STOP.
REQ-017 STOP: on a falling edge, check parity across 8 data bits plus the parity bit; an odd count passes.
REQ-018 STOP, stop bit 1 and parity passes: load dout and go to DONE.
REQ-019 STOP, parity fails: pulse parity_err, leave dout unchanged, go to IDLE.
REQ-020 STOP, stop bit 0: pulse frame_err and go to IDLE; frame_err takes priority over parity_err.
REQ-021 DONE: assert dout_new for exactly one cycle, which is the cycle after the stop-bit edge, then go to IDLE.
REQ-022 SHALL count clk cycles since the last accepted edge in DATA/PARITY/STOP; at TIMEOUT_CYCLES, pulse frame_err and go to IDLE.
REQ-023 SHALL clear the timeout counter on every accepted edge and while in IDLE; the counter is sized as $clog2(TIMEOUT_CYCLES+1).
REQ-024 dout SHALL hold its value between frames; dout_new, parity_err and frame_err SHALL never be asserted together.
REQ-025 An edge arriving in DONE SHALL be ignored, as a legal PS/2 bit period exceeds two cycles.
REQ-026 Unreachable state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-027 resetN low SHALL asynchronously force IDLE, dout=8'h00, dout_new=0, parity_err=0, frame_err=0, clear counters and shift register, and set synchronizer flops to 1 (idle bus level).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL be received normally.

Configuration
REQ-029 Macro PS2_GLITCH_FILTER_EN defined: kbd_clk SHALL pass through a FILTER_LEN-sample stability filter after synchronization, and edges are taken from the filtered level; latency grows by FILTER_LEN cycles.
REQ-030 Macro PS2_GLITCH_FILTER_EN undefined: edges SHALL be taken directly from the synchronized kbd_clk, and FILTER_LEN is unused.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum type, the frame length constant (11), and scan constants 8'hE0/8'hF0 shared with downstream decoding.
REQ-032 Sub-module ps2_edge_det SHALL contain the synchronizer, the optional filter and the falling-edge detect, outputting a synchronized data bit and an edge strobe.

Verification (50 MHz clk, 10 kHz kbd_clk model)
REQ-033 Frame 0x1C, parity 0, stop 1 -> dout=8'h1C, exactly one dout_new pulse, no error strobes.
REQ-034 Frame 0x1C with parity 1 -> one parity_err pulse, no dout_new, dout keeps its prior value.
REQ-035 Five bits of a frame, then hold for 50000 cycles -> one frame_err pulse; a following 0x29 frame -> dout=8'h29 with dout_new.
REQ-036 Falling edge with kbd_dat=1 in IDLE -> no strobes; the next valid 0xF0 frame (parity 1) -> dout=8'hF0.
REQ-037 resetN pulsed after bit 4 of a frame -> all outputs return to reset values; the next 0x1C frame is received correctly.
REQ-038 A 2-cycle low glitch on kbd_clk mid-frame -> with PS2_GLITCH_FILTER_EN, frame 0x1C is still received; without it, a parity_err or frame_err strobe is required.
